// File: rtl/ssb_hbridge_driver_if.sv
// Control/drive bundle for the SSB H-bridge carrier driver.
// master: SSB chain side (drives freq, offset, amplitude, stdby);
// slave: driver side (returns DRV0/DRV1, FSM state, slewed amplitude).
interface ssb_hbridge_driver_if #(
    parameter int PHASE_W  = 18,
    parameter int DPHASE_W = 14,
    parameter int AMP_W    = 24
);
    logic [PHASE_W-1:0]         ssb_freq;
    logic signed [DPHASE_W-1:0] delta_phase;
    logic [AMP_W-1:0]           amplitude;
    logic                       stdby;
    logic                       DRV0;
    logic                       DRV1;
    logic [1:0]                 state;
    logic [AMP_W-1:0]           amp_eff;

    modport master (
        output ssb_freq, delta_phase, amplitude, stdby,
        input  DRV0, DRV1, state, amp_eff
    );

    modport slave (
        input  ssb_freq, delta_phase, amplitude, stdby,
        output DRV0, DRV1, state, amp_eff
    );
endinterface

// File: rtl/ssb_hbridge_driver.sv
// SSB carrier driver: phase accumulator, slewed 3-level PWM, dead time,
// standby ramp FSM. Ports: clk, rst (async active-low), bus (slave).
module ssb_hbridge_driver #(
    parameter int PHASE_W     = 18,
    parameter int DPHASE_W    = 14,
    parameter int AMP_W       = 24,
    parameter int RAMP_STEP   = 65536,
    parameter int RAMP_DIV    = 1,
    parameter int DEAD_CYCLES = 2
) (
    input logic                clk,
    input logic                rst,
    ssb_hbridge_driver_if.slave bus
);
    localparam int SH  = AMP_W - PHASE_W + 1;
    localparam int DW  = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam int PVW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [AMP_W-1:0] STEP = AMP_W'(RAMP_STEP);
    localparam logic [PHASE_W-2:0] CTR = {1'b1, {(PHASE_W-2){1'b0}}};
    localparam logic [DW-1:0] DEAD = DW'(DEAD_CYCLES);
    localparam logic [PVW-1:0] PMAX = PVW'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RAMP_UP   = 2'b01,
        RUN       = 2'b10,
        RAMP_DOWN = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [AMP_W-1:0]   amp_q, amp_d;
    logic [PVW-1:0]     pre_q, pre_d;
    logic [DW-1:0]      dead_q, dead_d;
    logic               req0_q, req0_d, req1_q, req1_d;
    logic               drv0_q, drv0_d, drv1_q, drv1_d;

    logic [PHASE_W-1:0] inc;
    logic [PHASE_W-2:0] ph, hw, lo, hi;
    logic               active, tick;

    function automatic logic [AMP_W-1:0] toward(
        input logic [AMP_W-1:0] cur,
        input logic [AMP_W-1:0] tgt
    );
        if (cur < tgt)
            return (tgt - cur > STEP) ? cur + STEP : tgt;
        else
            return (cur - tgt > STEP) ? cur - STEP : tgt;
    endfunction

    assign inc  = bus.ssb_freq + PHASE_W'(bus.delta_phase);
    assign tick = (pre_q == PMAX);
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    // Window centred at a quarter turn; half-width never reaches CTR,
    // so lo/hi stay inside the half-cycle without extra clamping.
    assign ph     = acc_q[PHASE_W-2:0];
    assign hw     = {1'b0, amp_q[AMP_W-1:SH+1]};
    assign lo     = CTR - hw;
    assign hi     = CTR + hw;
    assign active = (ph >= lo) && (ph < hi);

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        acc_d   = acc_q + inc;
        unique case (state_q)
            IDLE: begin
                acc_d = '0;
                if (!bus.stdby) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (tick) amp_d = toward(amp_q, bus.amplitude);
                if (bus.stdby) state_d = RAMP_DOWN;
                else if (amp_q == bus.amplitude) state_d = RUN;
            end
            RUN: begin
                if (tick) amp_d = toward(amp_q, bus.amplitude);
                if (bus.stdby) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (tick) amp_d = toward(amp_q, '0);
                if (!bus.stdby) state_d = RAMP_UP;
                else if (amp_q == '0) begin
                    state_d = IDLE;
                    acc_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        req0_d = active && !acc_q[PHASE_W-1] && (state_q != IDLE);
        req1_d = active &&  acc_q[PHASE_W-1] && (state_q != IDLE);
        // Hold while requested; rise only with the other leg off
        // and the dead-time counter saturated.
        drv0_d = drv0_q ? req0_q : (req0_q && !drv1_q && dead_q == DEAD);
        drv1_d = drv1_q ? req1_q : (req1_q && !drv0_q && dead_q == DEAD);
        if (state_q == IDLE) begin
            drv0_d = 1'b0;
            drv1_d = 1'b0;
        end
        dead_d = dead_q;
        if ((drv0_q && !drv0_d) || (drv1_q && !drv1_d))
            dead_d = '0;
        else if (dead_q != DEAD)
            dead_d = dead_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            amp_q   <= '0;
            pre_q   <= '0;
            dead_q  <= DEAD;
            req0_q  <= 1'b0;
            req1_q  <= 1'b0;
            drv0_q  <= 1'b0;
            drv1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amp_q   <= amp_d;
            pre_q   <= pre_d;
            dead_q  <= dead_d;
            req0_q  <= req0_d;
            req1_q  <= req1_d;
            drv0_q  <= drv0_d;
            drv1_q  <= drv1_d;
        end
    end

    assign bus.DRV0    = drv0_q;
    assign bus.DRV1    = drv1_q;
    assign bus.state   = state_q;
    assign bus.amp_eff = amp_q;
endmodule

// File: doc/ssb_hbridge_driver.md
Name: ssb_hbridge_driver

Overview:
Parametrised next-generation SSB carrier driver for the H-bridge output stage. A phase accumulator (carrier word plus signed SSB offset) generates a 3-level drive on DRV0/DRV1, with pulse width set by an amplitude that is slewed to avoid step changes. Adds programmable dead time and a standby ramp-down/ramp-up state machine. Sits between the audio/SSB processing chain and the bridge gate drivers.

Parameters:
PHASE_W, 18, phase accumulator width; the carrier word is also PHASE_W bits.
DPHASE_W, 14, width of the signed frequency offset delta_phase.
AMP_W, 24, amplitude width, unsigned; must be >= PHASE_W.
RAMP_STEP, 65536, amplitude slew per ramp tick, in AMP_W units.
RAMP_DIV, 1, clock cycles per ramp tick; minimum 1.
DEAD_CYCLES, 2, minimum idle cycles between one drive falling and the other rising; 0 disables dead time.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
ssb_freq  in  PHASE_W  carrier phase increment, unsigned.
delta_phase  in  DPHASE_W  signed two's-complement SSB offset added to ssb_freq.
amplitude  in  AMP_W  target amplitude, unsigned.
stdby  in  1  1 = ramp down and idle; 0 = run.
DRV0  out  1  bridge leg A drive, positive half-cycle.
DRV1  out  1  bridge leg B drive, negative half-cycle.
state  out  2  00 IDLE, 01 RAMP_UP, 10 RUN, 11 RAMP_DOWN.
amp_eff  out  AMP_W  current slewed amplitude.

Behaviour:
- Reset (rst=0, asynchronous): acc=0, amp_eff=0, state=IDLE, DRV0=DRV1=0, dead-time counter=DEAD_CYCLES (drive permitted immediately), ramp prescaler=0.
- Phase: each cycle outside IDLE, acc <= acc + ssb_freq + sext(delta_phase), modulo 2^PHASE_W (wrap, no saturation). In IDLE acc is held at 0.
- Pulse: ph = acc[PHASE_W-2:0], C = 2^(PHASE_W-2), w = amp_eff >> (AMP_W-PHASE_W+1). Request is active when C - w/2 <= ph < C + w/2, with unsigned compares clamped to [0, 2^(PHASE_W-1)). r0 = active and acc MSB=0; r1 = active and acc MSB=1. r0 and r1 are mutually exclusive by construction.
- Latency: requests are registered 1 cycle after acc; DRV is registered 1 cycle after the requests. Total is 2 cycles from acc to pins.
- Dead time: a counter clears when either DRV falls, then counts up and saturates at DEAD_CYCLES. A DRV may rise only when its request is set, the other DRV is 0, and the counter equals DEAD_CYCLES. A DRV falls in the cycle after its request drops. DRV0 and DRV1 are never 1 together.
- Ramp tick: one pulse every RAMP_DIV cycles from a free-running prescaler.
- FSM, evaluated each cycle:
  - IDLE: outputs forced 0. If stdby=0, go to RAMP_UP.
  - RAMP_UP: on each tick, amp_eff += RAMP_STEP, saturating at amplitude. When amp_eff == amplitude, go to RUN. If stdby=1, go to RAMP_DOWN.
  - RUN: on each tick, amp_eff moves toward amplitude by min(RAMP_STEP, |diff|), in either direction. If stdby=1, go to RAMP_DOWN.
  - RAMP_DOWN: on each tick, amp_eff -= RAMP_STEP, saturating at 0. When amp_eff == 0, go to IDLE and clear acc. If stdby drops to 0, go to RAMP_UP from the current amp_eff, with no discontinuity.
- amplitude = 0 in RUN gives w=0: no pulses, and the FSM stays in RUN.
- Any amplitude or frequency change takes effect only through slewing (amplitude) or at the next accumulate (frequency). No glitch pulse shorter than 1 cycle is ever produced.
- Reset mid-pulse: both DRV drop asynchronously and immediately.

Test Plan:
- Release rst with stdby=0, ssb_freq=2^12, delta_phase=0, amplitude=2^22, RAMP_STEP=2^16, RAMP_DIV=1 -> RAMP_UP, then RUN after 64 ticks; amp_eff=2^22. Period is 64 cycles; DRV0 and DRV1 each give 8-cycle pulses centred in their half-cycles, 32 cycles apart.
- In RUN, step amplitude to 2^23 -> amp_eff slews in 64 ticks; pulses widen to 16 cycles; no overlap of DRV0 and DRV1.
- delta_phase=-2^10 with ssb_freq=2^12 -> effective increment 3072; period 85-86 cycles with correct wrap of acc.
- DEAD_CYCLES=4, amplitude=2^AMP_W-1 -> requests nearly abut; 4 idle cycles are enforced after each falling edge. Assert DRV0 & DRV1 never 1.
- stdby=1 in RUN -> RAMP_DOWN, amp_eff decreases to 0, IDLE, DRV low, acc=0. Drop stdby mid-ramp -> RAMP_UP resumes from the current amp_eff.
- Assert rst low mid-pulse -> DRV0/DRV1/amp_eff go 0 asynchronously and state=IDLE.
